// File: rtl/sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter
//
// Purpose:
//   Shares one asynchronous single-port SRAM between the instruction-fetch
//   (IF) stage and the load/store (MEM) stage. One requester is granted at a
//   time (MEM has priority). A three-state FSM (IDLE -> ACC -> DONE) holds
//   the SRAM strobes for WAIT_CYCLES cycles, captures read data at the end of
//   the access and returns a one-cycle ready pulse to the owner. The DONE
//   cycle keeps every strobe released so that a write is followed by a
//   recovery / bus-turnaround cycle before the next access.
//
// Parameters:
//   WAIT_CYCLES  SRAM access cycles per transaction (1..15)
//   SRAM_AW      SRAM word-address width
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req/if_addr           fetch request (held until if_ready), byte address
//   if_rdata/if_ready        fetched word, one-cycle completion pulse
//   mem_req/mem_we/mem_be    data request, 1=store, lane-aligned byte enables
//   mem_addr/mem_wdata       data byte address, lane-aligned store data
//   mem_rdata/mem_ready      full load word, one-cycle completion pulse
//   stallreq_if/stallreq_mem per-stage stall requests (combinational)
//   sram_ce_n/oe_n/we_n      SRAM chip/output/write enables (active-low)
//   sram_be_n                SRAM byte enables (active-low)
//   sram_addr                SRAM word address (byte address [SRAM_AW+1:2])
//   sram_dq_o/sram_dq_t      pad write data, 1 = pad tri-stated
//   sram_dq_i                pad read data
// ---------------------------------------------------------------------------
module sram_bus_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_rdata,
  output logic               if_ready,

  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [3:0]         mem_be,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_ready,

  output logic               stallreq_if,
  output logic               stallreq_mem,

  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_dq_o,
  output logic               sram_dq_t,
  input  logic [31:0]        sram_dq_i
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_MEM
  } owner_t;

  // Counter is loaded with WAIT_CYCLES-1 on grant; the access ends on the
  // edge that sees it at zero, giving exactly WAIT_CYCLES strobed cycles.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  owner_t     owner;
  logic [3:0] cnt;
  logic       acc_we;

  // Address bits below the word and above the SRAM window are ignored by
  // design; gathering them here documents that they are intentionally unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:SRAM_AW+2], if_addr[1:0],
                              mem_addr[31:SRAM_AW+2], mem_addr[1:0]};

  // Stall requests must drop in the ready cycle itself so the pipeline can
  // advance on the same edge that ends the transaction.
  assign stallreq_if  = if_req  & ~if_ready;
  assign stallreq_mem = mem_req & ~mem_ready;

  // Single FSM: grant, strobe sequencing, read capture and ready pulses.
  // Every SRAM pin is a register so the pads see glitch-free strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      cnt       <= 4'd0;
      acc_we    <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= 4'hF;
      sram_addr <= '0;
      sram_dq_o <= 32'd0;
      sram_dq_t <= 1'b1;
      if_rdata  <= 32'd0;
      mem_rdata <= 32'd0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          owner <= OWN_NONE;
          if (mem_req) begin
            owner     <= OWN_MEM;
            acc_we    <= mem_we;
            cnt       <= CNT_INIT;
            state     <= ACC;
            sram_ce_n <= 1'b0;
            sram_addr <= mem_addr[SRAM_AW+1:2];
            if (mem_we) begin
              sram_oe_n <= 1'b1;
              sram_we_n <= 1'b0;
              sram_be_n <= ~mem_be;
              sram_dq_t <= 1'b0;
              sram_dq_o <= mem_wdata;
            end else begin
              sram_oe_n <= 1'b0;
              sram_we_n <= 1'b1;
              sram_be_n <= 4'h0;
              sram_dq_t <= 1'b1;
            end
          end else if (if_req) begin
            owner     <= OWN_IF;
            acc_we    <= 1'b0;
            cnt       <= CNT_INIT;
            state     <= ACC;
            sram_ce_n <= 1'b0;
            sram_addr <= if_addr[SRAM_AW+1:2];
            sram_oe_n <= 1'b0;
            sram_we_n <= 1'b1;
            sram_be_n <= 4'h0;
            sram_dq_t <= 1'b1;
          end
        end

        ACC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!acc_we) begin
              if (owner == OWN_MEM) begin
                mem_rdata <= sram_dq_i;
              end else begin
                if_rdata <= sram_dq_i;
              end
            end
            if (owner == OWN_MEM) begin
              mem_ready <= 1'b1;
            end else begin
              if_ready <= 1'b1;
            end
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= 4'hF;
            sram_dq_t <= 1'b1;
            state     <= DONE;
          end
        end

        // Turnaround cycle: strobes stay released and no request is taken,
        // so a requester still holding req here is not served twice.
        DONE: begin
          if_ready  <= 1'b0;
          mem_ready <= 1'b0;
          owner     <= OWN_NONE;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_arbiter
//
// Purpose:
//   Scoreboard bench for sram_bus_arbiter. Drivers issue fetch/load/store
//   transactions and push the expected response (taken from a word-level
//   memory model) into per-requester queues; a monitor pops and compares
//   whenever a ready pulse appears. A behavioural SRAM pad model reacts to
//   the DUT pins. A second instance with WAIT_CYCLES=1 runs back-to-back
//   loads against a randomly changing data pad.
// ---------------------------------------------------------------------------
module tb_sram_bus_arbiter;

  localparam int W  = 2;
  localparam int AW = 20;

  typedef struct {
    bit          is_store;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (WAIT_CYCLES = 2) ----------------
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = 32'd0;
  logic [31:0]   if_rdata;
  logic          if_ready;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [3:0]    mem_be = 4'h0;
  logic [31:0]   mem_addr = 32'd0;
  logic [31:0]   mem_wdata = 32'd0;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          stallreq_if;
  logic          stallreq_mem;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [3:0]    sram_be_n;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_dq_o;
  logic          sram_dq_t;
  logic [31:0]   sram_dq_i = 32'd0;

  sram_bus_arbiter #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_t(sram_dq_t), .sram_dq_i(sram_dq_i)
  );

  // ---------------- second DUT (WAIT_CYCLES = 1) ----------------
  logic          b_if_req = 1'b0;
  logic [31:0]   b_if_addr = 32'd0;
  logic [31:0]   b_if_rdata;
  logic          b_if_ready;
  logic          b_mem_req = 1'b1;
  logic          b_mem_we = 1'b0;
  logic [3:0]    b_mem_be = 4'hF;
  logic [31:0]   b_mem_addr = 32'h0000_0040;
  logic [31:0]   b_mem_wdata = 32'd0;
  logic [31:0]   b_mem_rdata;
  logic          b_mem_ready;
  logic          b_stallreq_if;
  logic          b_stallreq_mem;
  logic          b_sram_ce_n;
  logic          b_sram_oe_n;
  logic          b_sram_we_n;
  logic [3:0]    b_sram_be_n;
  logic [AW-1:0] b_sram_addr;
  logic [31:0]   b_sram_dq_o;
  logic          b_sram_dq_t;
  logic [31:0]   b_sram_dq_i = 32'd0;

  sram_bus_arbiter #(.WAIT_CYCLES(1), .SRAM_AW(AW)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
    .stallreq_if(b_stallreq_if), .stallreq_mem(b_stallreq_mem),
    .sram_ce_n(b_sram_ce_n), .sram_oe_n(b_sram_oe_n), .sram_we_n(b_sram_we_n),
    .sram_be_n(b_sram_be_n), .sram_addr(b_sram_addr), .sram_dq_o(b_sram_dq_o),
    .sram_dq_t(b_sram_dq_t), .sram_dq_i(b_sram_dq_i)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  exp_t        mem_q[$];
  logic [31:0] if_q[$];

  logic [31:0] pad_mem [int];
  logic [31:0] ref_mem [int];
  logic [31:0] pad_w;

  int          access_cnt = 0;
  int          ready_cnt  = 0;
  logic        prev_ce_n  = 1'b1;
  logic        prev_if_ready = 1'b0;
  logic        prev_mem_ready = 1'b0;
  logic [31:0] last_mem_load = 32'd0;

  int          b_gap = -1;
  int          b_ready_cnt = 0;
  logic [31:0] b_last_dq = 32'd0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Initial SRAM contents, shared by the pad and the reference model.
  function automatic logic [31:0] init_word(input int idx);
    return (32'(idx) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] pad_get(input int idx);
    return pad_mem.exists(idx) ? pad_mem[idx] : init_word(idx);
  endfunction

  function automatic logic [31:0] ref_get(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  function automatic logic [31:0] make_addr(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[AW+1:2] = AW'(idx);
    return a;
  endfunction

  // ---------------- SRAM pad model ----------------
  // Writes enabled bytes while a write strobe is active; drives stored data
  // only while output-enabled, random junk otherwise.
  always @(negedge clk) begin
    if (rst && !sram_ce_n && !sram_we_n && !sram_dq_t) begin
      pad_w = pad_get(int'(sram_addr));
      for (int b = 0; b < 4; b++) begin
        if (!sram_be_n[b]) pad_w[b*8 +: 8] = sram_dq_o[b*8 +: 8];
      end
      pad_mem[int'(sram_addr)] = pad_w;
    end
    if (!sram_ce_n && !sram_oe_n) sram_dq_i = pad_get(int'(sram_addr));
    else sram_dq_i = $urandom;
  end

  // ---------------- monitor / scoreboard (main DUT) ----------------
  always @(negedge clk) begin
    if (!rst) begin
      prev_ce_n      = 1'b1;
      prev_if_ready  = 1'b0;
      prev_mem_ready = 1'b0;
      last_mem_load  = 32'd0;
    end else if (mon_en) begin
      if (if_ready) begin
        ready_cnt++;
        check_output("if_ready_single", 32'(prev_if_ready), 32'd0);
        if (if_q.size() == 0) check_output("if_unexpected_ready", 32'd1, 32'd0);
        else check_output("if_rdata", if_rdata, if_q.pop_front());
      end
      if (mem_ready) begin
        exp_t e;
        ready_cnt++;
        check_output("mem_ready_single", 32'(prev_mem_ready), 32'd0);
        if (mem_q.size() == 0) check_output("mem_unexpected_ready", 32'd1, 32'd0);
        else begin
          e = mem_q.pop_front();
          if (e.is_store) check_output("mem_rdata_hold", mem_rdata, last_mem_load);
          else begin
            check_output("mem_rdata", mem_rdata, e.data);
            last_mem_load = e.data;
          end
        end
      end
      if (if_ready && mem_ready) check_output("ready_exclusive", 32'd1, 32'd0);
      check_output("stallreq_if", 32'(stallreq_if), 32'(if_req & ~if_ready));
      check_output("stallreq_mem", 32'(stallreq_mem), 32'(mem_req & ~mem_ready));
      if (!sram_ce_n && !sram_oe_n)
        check_output("read_pins", {26'd0, sram_we_n, sram_dq_t, sram_be_n}, {26'd0, 6'b110000});
      if (!sram_ce_n && !sram_we_n)
        check_output("write_pins", {30'd0, sram_oe_n, sram_dq_t}, 32'd2);
      if (sram_ce_n)
        check_output("idle_pins", {25'd0, sram_oe_n, sram_we_n, sram_be_n, sram_dq_t}, 32'h7F);
      if (!sram_ce_n && prev_ce_n) access_cnt++;
      prev_ce_n      = sram_ce_n;
      prev_if_ready  = if_ready;
      prev_mem_ready = mem_ready;
    end
  end

  // ---------------- monitor for WAIT_CYCLES=1 back-to-back loads ----------------
  always @(negedge clk) begin
    if (!rst) begin
      b_gap = -1;
    end else if (mon_en) begin
      if (b_gap >= 0) b_gap++;
      if (b_mem_ready) begin
        check_output("b_mem_rdata", b_mem_rdata, b_last_dq);
        if (b_gap >= 0) check_output("b_ready_period", 32'(b_gap), 32'd3);
        b_gap = 0;
        b_ready_cnt++;
      end
    end
    b_last_dq   = $urandom;
    b_sram_dq_i = b_last_dq;
  end

  // ---------------- driver ----------------
  // Entered and left #1 after a rising edge. Holds req through the ready
  // cycle and drops it just after, like a pipeline stage would.
  task automatic apply_stimulus(
    input  bit            is_if,
    input  bit            we,
    input  logic [3:0]    be,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output int            lat,
    output int            act,
    output logic [3:0]    be_n_s,
    output logic          we_n_s,
    output logic          oe_n_s,
    output logic          dq_t_s,
    output logic [31:0]   dq_o_s,
    output logic [AW-1:0] addr_s,
    output logic          done_we_n
  );
    int          idx;
    logic [31:0] w;
    exp_t        e;
    idx = int'(addr[AW+1:2]);
    lat = 0; act = 0;
    be_n_s = 4'h0; we_n_s = 1'b1; oe_n_s = 1'b1; dq_t_s = 1'b1;
    dq_o_s = 32'd0; addr_s = '0; done_we_n = 1'b0;
    if (is_if) begin
      if_q.push_back(ref_get(idx));
      if_addr = addr;
      if_req  = 1'b1;
    end else begin
      if (we) begin
        w = ref_get(idx);
        for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
        ref_mem[idx] = w;
        e.is_store = 1'b1; e.data = 32'd0;
      end else begin
        e.is_store = 1'b0; e.data = ref_get(idx);
      end
      mem_q.push_back(e);
      mem_we = we; mem_be = be; mem_addr = addr; mem_wdata = wdata;
      mem_req = 1'b1;
    end
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (is_if ? if_ready : mem_ready) begin
        done_we_n = sram_we_n;
        break;
      end
      if (!sram_ce_n) begin
        act++;
        be_n_s = sram_be_n; we_n_s = sram_we_n; oe_n_s = sram_oe_n;
        dq_t_s = sram_dq_t; dq_o_s = sram_dq_o; addr_s = sram_addr;
      end
      if (lat > 200) begin
        checks++; failures++;
        $display("[TB] FAIL txn_timeout actual=%0d cycles required=ready", lat);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (is_if) if_req = 1'b0;
    else mem_req = 1'b0;
  endtask

  task automatic random_if_txns(input int n);
    int gap, lat, act;
    logic [3:0] s4; logic s1, s2, s3, s5; logic [31:0] s32; logic [AW-1:0] sa;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      apply_stimulus(1'b1, 1'b0, 4'h0, make_addr($urandom_range(16, 31)), 32'd0,
                     lat, act, s4, s1, s2, s3, s32, sa, s5);
    end
  endtask

  task automatic random_mem_txns(input int n);
    int gap, lat, act;
    bit we;
    logic [3:0] s4; logic s1, s2, s3, s5; logic [31:0] s32; logic [AW-1:0] sa;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      we  = 1'($urandom_range(0, 1));
      repeat (gap) begin @(posedge clk); #1; end
      apply_stimulus(1'b0, we, 4'($urandom_range(0, 15)), make_addr($urandom_range(32, 39)),
                     $urandom, lat, act, s4, s1, s2, s3, s32, sa, s5);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, lat2, act, act2;
    logic [3:0] be_n_s, be_n_s2;
    logic we_n_s, oe_n_s, dq_t_s, done_we_n, we_n_s2, oe_n_s2, dq_t_s2, done_we_n2;
    logic [31:0] dq_o_s, dq_o_s2;
    logic [AW-1:0] addr_s, addr_s2;

    // Directed contents: fetch word and contention load word.
    pad_mem[4] = 32'h3C08_ABCD; ref_mem[4] = 32'h3C08_ABCD;
    pad_mem[0] = 32'h1234_5678; ref_mem[0] = 32'h1234_5678;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    check_output("rst_be_n", 32'(sram_be_n), 32'hF);
    check_output("rst_addr", 32'(sram_addr), 32'd0);
    check_output("rst_dq", {sram_dq_o[30:0], sram_dq_t}, 32'd1);
    check_output("rst_rdata", if_rdata | mem_rdata, 32'd0);
    check_output("rst_ready", {30'd0, if_ready, mem_ready}, 32'd0);
    rst = 1'b1;
    mon_en = 1'b1;

    // Reset in the middle of a store
    @(posedge clk); #1;
    mem_we = 1'b1; mem_be = 4'hF; mem_addr = make_addr(100); mem_wdata = 32'hCAFE_F00D;
    mem_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    check_output("abort_in_acc", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b0;
    #1;
    check_output("abort_pins", {29'd0, sram_ce_n, sram_we_n, sram_dq_t}, 32'd7);
    check_output("abort_no_ready", 32'(mem_ready), 32'd0);
    mem_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_output("abort_idle", {31'd0, sram_ce_n}, 32'd1);

    // Single fetch
    apply_stimulus(1'b1, 1'b0, 4'h0, 32'h8000_0010, 32'd0,
                   lat, act, be_n_s, we_n_s, oe_n_s, dq_t_s, dq_o_s, addr_s, done_we_n);
    check_output("fetch_latency", 32'(lat), 32'(W + 1));
    check_output("fetch_active_cycles", 32'(act), 32'(W));
    check_output("fetch_sram_addr", 32'(addr_s), 32'h4);
    check_output("fetch_oe_n", 32'(oe_n_s), 32'd0);

    // Byte store
    @(posedge clk); #1;
    apply_stimulus(1'b0, 1'b1, 4'b0100, 32'h8040_0006, 32'h00AB_0000,
                   lat, act, be_n_s, we_n_s, oe_n_s, dq_t_s, dq_o_s, addr_s, done_we_n);
    check_output("store_be_n", 32'(be_n_s), 32'hB);
    check_output("store_we_dqt", {30'd0, we_n_s, dq_t_s}, 32'd0);
    check_output("store_dq_o", dq_o_s, 32'h00AB_0000);
    check_output("store_active_cycles", 32'(act), 32'(W));
    check_output("store_done_we_n", 32'(done_we_n), 32'd1);
    check_output("store_latency", 32'(lat), 32'(W + 1));

    // Read back the stored word
    apply_stimulus(1'b0, 1'b0, 4'hF, make_addr(1), 32'd0,
                   lat, act, be_n_s, we_n_s, oe_n_s, dq_t_s, dq_o_s, addr_s, done_we_n);

    // Contention: both requests rise together
    @(posedge clk); #1;
    fork
      apply_stimulus(1'b0, 1'b0, 4'hF, 32'h8040_0000, 32'd0,
                     lat, act, be_n_s, we_n_s, oe_n_s, dq_t_s, dq_o_s, addr_s, done_we_n);
      apply_stimulus(1'b1, 1'b0, 4'h0, make_addr(16), 32'd0,
                     lat2, act2, be_n_s2, we_n_s2, oe_n_s2, dq_t_s2, dq_o_s2, addr_s2, done_we_n2);
    join
    check_output("contention_mem_latency", 32'(lat), 32'(W + 1));
    check_output("contention_if_latency", 32'(lat2), 32'(2 * W + 3));

    // Randomised concurrent traffic
    fork
      random_if_txns(25);
      random_mem_txns(30);
    join

    repeat (5) @(posedge clk);
    #1;
    check_output("if_queue_empty", 32'(if_q.size()), 32'd0);
    check_output("mem_queue_empty", 32'(mem_q.size()), 32'd0);
    check_output("one_access_per_ready", 32'(access_cnt), 32'(ready_cnt + 1));
    check_output("b_enough_pulses", 32'(b_ready_cnt >= 10), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
